// File: rtl/serial_add_ctrl_if.sv
// Bundle of start/operand inputs and result/status outputs for serial_add_ctrl.
// Handshake: an operation is accepted on a rising edge where start && ready; done pulses
// for exactly one cycle with sum/cout/ovf final, and they hold until the next acceptance.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       dbg_state;

    modport master (
        output start, sub, opa, opb, cin,
        input  ready, busy, done, sum, cout, ovf, dbg_state
    );

    modport slave (
        input  start, sub, opa, opb, cin,
        output ready, busy, done, sum, cout, ovf, dbg_state
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell reused LSB-first over WIDTH clocks,
// carry held in a flop, result assembled in a right-shifting register.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last_bit;
    logic             ready_c;
    logic             busy_c;
    logic             done_c;

    full_adder u_fa (
        .a     (sha[0]),
        .b     (shb[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha    <= '0;
            shb    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            sha    <= bus.opa;
            shb    <= bus.sub ? ~bus.opb : bus.opb;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            carry <= fa_carry;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                // carry still holds the carry into the MSB on this edge
                ovf_r  <= carry ^ fa_carry;
                cout_r <= fa_carry;
            end
        end
    end

    assign bus.ready     = ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbg_state = state;
endmodule
